// File: rtl/pal_cfg_loader.sv
// Byte-to-serial configuration loader for the PAL array: takes SR_LEN bits as bytes from
// the host and clocks them, LSB first, into the PAL configuration chain via en/cfg.
module pal_cfg_loader #(
    parameter int N = 8,
    parameter int P = 8,
    parameter int M = 8
) (
    input  logic       clk,
    input  logic       res_n,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       byte_ready,
    output logic       sr_en,
    output logic       sr_cfg,
    output logic       busy,
    output logic       done,
    output logic       cfg_valid,
    output logic [1:0] dbg_state
);

    localparam int SR_LEN = 2*N*P + P*M;
    localparam int NBYTES = (SR_LEN + 7) / 8;
    localparam int CW     = $clog2(SR_LEN + 1);
    localparam int BW     = $clog2(NBYTES + 1);
    localparam logic [3:0] LAST_CNT = ((SR_LEN % 8) == 0) ? 4'd8 : 4'(SR_LEN % 8);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] bits_left_q, bits_left_d;
    logic [BW-1:0] bytes_left_q, bytes_left_d;
    logic [7:0]    sh_q, sh_d;
    logic [3:0]    sh_cnt_q, sh_cnt_d;
    logic [7:0]    buf_q, buf_d;
    logic [3:0]    buf_cnt_q, buf_cnt_d;
    logic          cfg_valid_q, cfg_valid_d;

    logic          shifting;
    logic          accept;
    logic          sh_free;
    logic [3:0]    in_cnt;

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready; byte_ready
    // depends only on registered state, and byte_in must be held while byte_valid waits.
    always_comb begin
        shifting   = (state_q == LOAD) && (sh_cnt_q != 4'd0);
        byte_ready = (state_q == LOAD) && (buf_cnt_q == 4'd0) && (bytes_left_q != '0);
        accept     = byte_valid && byte_ready;
        sh_free    = (sh_cnt_q <= 4'd1);
        // Only the final byte can be short when the chain is not a whole number of bytes.
        in_cnt     = (bytes_left_q == BW'(1)) ? LAST_CNT : 4'd8;

        sr_en      = shifting;
        sr_cfg     = shifting & sh_q[0];
        busy       = (state_q != IDLE);
        done       = (state_q == DONE);
        cfg_valid  = cfg_valid_q;
        dbg_state  = state_q;
    end

    always_comb begin
        state_d      = state_q;
        bits_left_d  = bits_left_q;
        bytes_left_d = bytes_left_q;
        sh_d         = sh_q;
        sh_cnt_d     = sh_cnt_q;
        buf_d        = buf_q;
        buf_cnt_d    = buf_cnt_q;
        cfg_valid_d  = cfg_valid_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = LOAD;
                    cfg_valid_d  = 1'b0;
                    bits_left_d  = CW'(SR_LEN);
                    bytes_left_d = BW'(NBYTES);
                    sh_d         = '0;
                    sh_cnt_d     = '0;
                    buf_d        = '0;
                    buf_cnt_d    = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d      = IDLE;
                    bits_left_d  = '0;
                    bytes_left_d = '0;
                    sh_d         = '0;
                    sh_cnt_d     = '0;
                    buf_d        = '0;
                    buf_cnt_d    = '0;
                end else begin
                    if (shifting) begin
                        sh_d        = {1'b0, sh_q[7:1]};
                        sh_cnt_d    = sh_cnt_q - 4'd1;
                        bits_left_d = bits_left_q - CW'(1);
                    end
                    // Refill SH in the cycle it empties so consecutive bytes shift with no gap.
                    if (sh_free) begin
                        if (buf_cnt_q != 4'd0) begin
                            sh_d      = buf_q;
                            sh_cnt_d  = buf_cnt_q;
                            buf_d     = '0;
                            buf_cnt_d = '0;
                        end else if (accept) begin
                            sh_d     = byte_in;
                            sh_cnt_d = in_cnt;
                        end
                    end else if (accept) begin
                        buf_d     = byte_in;
                        buf_cnt_d = in_cnt;
                    end
                    if (accept) begin
                        bytes_left_d = bytes_left_q - BW'(1);
                    end
                    if (shifting && (bits_left_q == CW'(1))) begin
                        state_d     = DONE;
                        cfg_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q      <= IDLE;
            bits_left_q  <= '0;
            bytes_left_q <= '0;
            sh_q         <= '0;
            sh_cnt_q     <= '0;
            buf_q        <= '0;
            buf_cnt_q    <= '0;
            cfg_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bits_left_q  <= bits_left_d;
            bytes_left_q <= bytes_left_d;
            sh_q         <= sh_d;
            sh_cnt_q     <= sh_cnt_d;
            buf_q        <= buf_d;
            buf_cnt_q    <= buf_cnt_d;
            cfg_valid_q  <= cfg_valid_d;
        end
    end

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Directed bench for pal_cfg_loader: default 192-bit chain plus a 21-bit instance,
// with a bit-level expected queue and a model of the PAL chain contents.
`timescale 1ns/1ps
module tb_pal_cfg_loader;

    localparam int SR_LEN = 192;
    localparam int NBYTES = 24;
    localparam int SR2    = 21;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic res_n;

    logic       start, abort, byte_valid;
    logic [7:0] byte_in;
    logic       byte_ready, sr_en, sr_cfg, busy, done, cfg_valid;
    logic [1:0] dbg_state;

    logic       start2, abort2, byte_valid2;
    logic [7:0] byte_in2;
    logic       byte_ready2, sr_en2, sr_cfg2, busy2, done2, cfg_valid2;
    logic [1:0] dbg_state2;

    pal_cfg_loader u_dut (
        .clk(clk), .res_n(res_n), .start(start), .abort(abort),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
        .sr_en(sr_en), .sr_cfg(sr_cfg), .busy(busy), .done(done),
        .cfg_valid(cfg_valid), .dbg_state(dbg_state)
    );

    pal_cfg_loader #(.N(3), .P(3), .M(1)) u_dut2 (
        .clk(clk), .res_n(res_n), .start(start2), .abort(abort2),
        .byte_in(byte_in2), .byte_valid(byte_valid2), .byte_ready(byte_ready2),
        .sr_en(sr_en2), .sr_cfg(sr_cfg2), .busy(busy2), .done(done2),
        .cfg_valid(cfg_valid2), .dbg_state(dbg_state2)
    );

    logic [7:0] stream [NBYTES] = '{
        8'h5A, 8'h3C, 8'hF0, 8'h0F, 8'hA5, 8'hC3, 8'h81, 8'h7E,
        8'h01, 8'h80, 8'hFF, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78,
        8'h9A, 8'hBC, 8'hDE, 8'hF1, 8'hE7, 8'h18, 8'h66, 8'h99
    };

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail  = 0;
    logic [0:0] exp_q[$];

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Stream bit k ends at chain position SR_LEN-1-k.
    function automatic logic [SR_LEN-1:0] exp_chain();
        logic [SR_LEN-1:0] c;
        c = '0;
        for (int k = 0; k < SR_LEN; k++) c[SR_LEN-1-k] = stream[k/8][k%8];
        return c;
    endfunction

    // ---------------- monitor (negedge) ----------------
    int cyc = 0, en_cnt = 0, cur_run = 0, max_run = 0, done_cnt = 0, done_cyc = 0;
    int en_cnt2 = 0, done_cnt2 = 0;
    logic [SR_LEN-1:0] chain = '0;
    logic [SR2-1:0]    chain2 = '0;

    initial begin
        logic [0:0] exp_bit;
        forever begin
            @(negedge clk);
            cyc++;
            if (sr_en === 1'b1) begin
                en_cnt++;
                cur_run++;
                if (cur_run > max_run) max_run = cur_run;
                chain = {chain[SR_LEN-2:0], sr_cfg};
                check("bit_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    exp_bit = exp_q.pop_front();
                    check("bit", sr_cfg, exp_bit);
                end
            end else begin
                cur_run = 0;
                check("cfg_when_idle", sr_cfg, 0);
            end
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (sr_en2 === 1'b1) begin
                en_cnt2++;
                chain2 = {chain2[SR2-2:0], sr_cfg2};
            end
            if (done2 === 1'b1) done_cnt2++;
        end
    end

    // ---------------- driver tasks ----------------
    int start_cyc = 0;

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clr_mon();
        en_cnt = 0; cur_run = 0; max_run = 0; done_cnt = 0; chain = '0;
        en_cnt2 = 0; done_cnt2 = 0; chain2 = '0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(posedge clk);
        start_cyc = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic push_byte(input logic [7:0] b);
        int g;
        byte_in    = b;
        byte_valid = 1'b1;
        g = 0;
        while (!byte_ready && g < 1000) begin
            tick();
            g++;
        end
        if (g >= 1000) check("accept_timeout", g, 0);
        else for (int j = 0; j < 8; j++) exp_q.push_back(b[j]);
        tick();
        byte_valid = 1'b0;
    endtask

    task automatic wait_en(input int n);
        int g;
        g = 0;
        while (en_cnt < n && g < 2000) begin
            tick();
            g++;
        end
        check("wait_en", en_cnt, n);
    endtask

    task automatic wait_done();
        int g;
        g = 0;
        while (done_cnt == 0 && g < 1000) begin
            tick();
            g++;
        end
        check("done_seen", done_cnt, 1);
        check("done_cfg_valid", cfg_valid, 1);
    endtask

    task automatic run_load(input bit stall, input int restart_at);
        do_start();
        check("start_busy", busy, 1);
        check("start_ready", byte_ready, 1);
        for (int i = 0; i < NBYTES; i++) begin
            push_byte(stream[i]);
            if (stall && (i == 3 || i == 17)) repeat (5) tick();
            if (i == restart_at) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end
        end
        wait_done();
        tick();
        check("post_busy", busy, 0);
        tick();
    endtask

    // ---------------- main sequence ----------------
    logic [SR_LEN-1:0] ref_chain;
    int acc2;
    logic ok;

    initial begin
        res_n = 1'b0; start = 1'b0; abort = 1'b0; byte_valid = 1'b0; byte_in = '0;
        start2 = 1'b0; abort2 = 1'b0; byte_valid2 = 1'b0; byte_in2 = '0;
        repeat (3) tick();
        res_n = 1'b1;
        tick();
        check("rst_byte_ready", byte_ready, 0);
        check("rst_sr_en", sr_en, 0);
        check("rst_sr_cfg", sr_cfg, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_state", dbg_state, 0);

        // Gap-free load: 192 consecutive shifts, done in cycle start+194.
        clr_mon();
        run_load(1'b0, -1);
        check("t1_en_cnt", en_cnt, SR_LEN);
        check("t1_max_run", max_run, SR_LEN);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_done_lat", done_cyc - start_cyc, SR_LEN + 2);
        check("t1_cfg_valid", cfg_valid, 1);
        check("t1_exp_empty", exp_q.size(), 0);
        check("t1_chain", chain, exp_chain());
        ref_chain = chain;

        // Host stalls after bytes 3 and 17.
        clr_mon();
        run_load(1'b1, -1);
        check("t2_en_cnt", en_cnt, SR_LEN);
        check("t2_done_cnt", done_cnt, 1);
        check("t2_chain", chain, ref_chain);
        check("t2_cfg_valid", cfg_valid, 1);

        // Abort after bit 100.
        clr_mon();
        do_start();
        check("t3_cfg_cleared", cfg_valid, 0);
        for (int i = 0; i < 13; i++) push_byte(stream[i]);
        wait_en(100);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t3_sr_en", sr_en, 0);
        check("t3_en_cnt", en_cnt, 100);
        check("t3_busy", busy, 0);
        check("t3_ready", byte_ready, 0);
        check("t3_cfg_valid", cfg_valid, 0);
        exp_q.delete();
        repeat (20) tick();
        check("t3_no_done", done_cnt, 0);
        check("t3_en_hold", en_cnt, 100);
        check("t3_state", dbg_state, 0);
        clr_mon();
        run_load(1'b0, -1);
        check("t3_reload_en", en_cnt, SR_LEN);
        check("t3_reload_chain", chain, ref_chain);
        check("t3_reload_cfg_valid", cfg_valid, 1);

        // start pulsed mid-load is ignored.
        clr_mon();
        run_load(1'b0, 10);
        check("t4_en_cnt", en_cnt, SR_LEN);
        check("t4_done_cnt", done_cnt, 1);
        check("t4_chain", chain, ref_chain);

        // Asynchronous reset at bit 50.
        clr_mon();
        do_start();
        for (int i = 0; i < 7; i++) push_byte(stream[i]);
        wait_en(50);
        res_n = 1'b0;
        #1;
        check("t5_sr_en", sr_en, 0);
        check("t5_sr_cfg", sr_cfg, 0);
        check("t5_busy", busy, 0);
        check("t5_ready", byte_ready, 0);
        check("t5_done", done, 0);
        check("t5_cfg_valid", cfg_valid, 0);
        check("t5_state", dbg_state, 0);
        tick();
        res_n = 1'b1;
        exp_q.delete();
        tick();
        clr_mon();
        run_load(1'b0, -1);
        check("t5_reload_en", en_cnt, SR_LEN);
        check("t5_reload_chain", chain, ref_chain);
        check("t5_reload_cfg_valid", cfg_valid, 1);

        // 21-bit chain: 0xFF, 0x00, 0xFF with byte_valid held throughout.
        clr_mon();
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        byte_in2    = 8'hFF;
        byte_valid2 = 1'b1;
        acc2 = 0;
        for (int c = 0; c < 60; c++) begin
            ok = byte_ready2;
            tick();
            if (ok) begin
                acc2++;
                byte_in2 = (acc2 == 1) ? 8'h00 : 8'hFF;
            end
        end
        check("t6_accepts", acc2, 3);
        check("t6_ready_low", byte_ready2, 0);
        check("t6_en_cnt", en_cnt2, SR2);
        check("t6_chain", chain2, 21'h1FE01F);
        check("t6_done_cnt", done_cnt2, 1);
        check("t6_cfg_valid", cfg_valid2, 1);
        check("t6_busy", busy2, 0);
        byte_valid2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/pal_cfg_loader.md
# pal_cfg_loader

Configuration controller for the PAL array. It accepts a configuration bitstream from a host as bytes over a valid/ready handshake and serialises it, one bit per cycle, into the PAL configuration shift register through that register's `en` and `cfg` inputs. It counts exactly `SR_LEN` bits and then flags the array configuration as valid. It sits between the host/SPI-side byte source and the PAL, and it owns the PAL's `en`/`cfg` pins.

## Interface
- `N`, 8, number of PAL inputs
- `P`, 8, number of product terms
- `M`, 8, number of PAL outputs
- `SR_LEN` (localparam), 2*N*P + P*M, configuration chain length; 192 at defaults
- `NBYTES` (localparam), ceil(SR_LEN/8), bytes per load; 24 at defaults

Ports:
- `clk` in 1: single clock; all logic is on the rising edge
- `res_n` in 1: reset, asynchronous, active-low
- `start` in 1: begin a load; sampled only in IDLE
- `abort` in 1: cancel the load in progress
- `byte_in` in 8: configuration byte
- `byte_valid` in 1: `byte_in` is valid
- `byte_ready` out 1: the loader accepts `byte_in` this cycle
- `sr_en` out 1: drives the PAL `en` pin (shift enable)
- `sr_cfg` out 1: drives the PAL `cfg` pin (serial bit)
- `busy` out 1: a load is in progress
- `done` out 1: one-cycle pulse when a load completes
- `cfg_valid` out 1: the PAL holds a complete configuration

## Operation
- States: IDLE, LOAD, DONE.
- IDLE: all outputs 0 except `cfg_valid`, which holds its value.
  - `start`=1 → LOAD.
  - On entry to LOAD: `cfg_valid` is cleared, the bit counter is set to `SR_LEN`, the byte counter to `NBYTES`, and both data registers are emptied.
- Data registers:
  - Shift register SH: 8 bits plus a bits-left count.
  - One-entry buffer BUF: feeds SH so bits can shift back-to-back.
- `byte_ready` = (state==LOAD) && !BUF_full && bytes_accepted < `NBYTES`.
- A byte is accepted when `byte_valid` && `byte_ready` at a rising edge.
  - If SH is empty, or SH is emptying this cycle, the byte loads straight into SH.
  - Otherwise it goes into BUF.
- Shifting:
  - In every cycle that SH is non-empty, `sr_en`=1 and `sr_cfg`=SH[0].
  - SH shifts right and the bit counter decrements.
  - When SH empties and BUF is full, BUF moves into SH with no gap cycle.
- Bit order:
  - LSB of each byte is sent first; byte 0 is sent first.
  - Stream bit k (k = 8*byte + bit) lands in chain position `SR_LEN`-1-k once the load completes.
- Last byte: when `SR_LEN` mod 8 ≠ 0, only the low (`SR_LEN` mod 8) bits are shifted and the upper bits are discarded.
- Completion: when the bit counter reaches 0 → DONE for one cycle.
  - `done`=1 and `cfg_valid`=1 in that cycle.
  - Then → IDLE; `cfg_valid` stays 1.
- `start` while LOAD or DONE is ignored.
- `abort` in LOAD:
  - Next state is IDLE.
  - SH, BUF and the counters are cleared; `sr_en`=0 from the next cycle.
  - `cfg_valid` stays 0 and no `done` pulse is generated.
  - `abort` in IDLE or DONE has no effect.
  - `abort` has priority over any byte accept in the same cycle.
- `sr_cfg` = 0 whenever `sr_en` = 0.

## Timing
- Reset: state = IDLE. `byte_ready`, `sr_en`, `sr_cfg`, `busy`, `done` and `cfg_valid` are all 0; counters are 0.
- `start` sampled at edge t → `busy`=1 and `byte_ready`=1 from cycle t+1.
- Byte accepted at edge a → its bits appear on `sr_cfg` in cycles a+1 … a+8 (SH was empty).
- Continuous `byte_valid` → `sr_en` is high for `SR_LEN` consecutive cycles.
  - Minimum load time: `SR_LEN`+2 cycles from `start` to `done`.
- Last bit shifted in cycle c → `done`=1 and `cfg_valid`=1 in cycle c+1; `busy`=0 from c+2.
- `byte_ready` deasserts after `NBYTES` bytes are accepted. Extra `byte_valid` is ignored and no byte is consumed.
- Host stall (SH and BUF both empty) → `sr_en`=0. The bit counter holds and no bit is lost or duplicated.
- `res_n` low at any time → immediate return to reset values, even mid-shift.

## Test plan
- Default params, `start` followed by 24 bytes back-to-back:
  - `sr_en` high for exactly 192 consecutive cycles.
  - `done` pulses once, at cycle 194 after the `start` edge.
  - With the stream set to a known OR/AND pattern and the PAL connected, `OUTPUT_VALS[0]` = IN0 & ~IN1 for all 256 input values.
- Stalls: `byte_valid` deasserted for 5 cycles after bytes 3 and 17:
  - `sr_en` shows gaps only in those periods.
  - Total `sr_en` count is 192; the resulting chain matches the gap-free run bit for bit.
- N=3, P=3, M=1 (`SR_LEN`=21): three bytes 0xFF, 0x00, 0xFF:
  - 21 `sr_en` pulses.
  - Last byte contributes 5 ones; bits 5–7 are discarded.
  - `byte_ready` low after the third byte even with `byte_valid` held.
- `abort` after bit 100:
  - `sr_en`=0 from the next cycle, `cfg_valid`=0, no `done` pulse.
  - A subsequent full load completes normally.
- `start` pulsed again mid-load: no restart, total shifted bits = 192.
- `res_n` dropped at bit 50, then released: all outputs 0. A new load then completes with `cfg_valid`=1.
